// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered execute stage around the combinational ALU_32.
// A one-entry issue register drives the ALU. Each issued op is captured into a
// result FIFO, which is drained over a valid/ready handshake.
// Optional feature: define ALU_EXEC_STICKY_EN to enable the sticky overflow flop.
module alu_exec_stage #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_ctrl,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [31:0]      alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic [2:0]       res_flags,
  output logic             res_illegal,
  output logic [15:0]      op_count,
  output logic             sticky_ovf,
  input  logic             sticky_clr
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned EntW  = 1 + 3 + TAG_W + 32;
  localparam logic [PtrW:0] DepthW = (PtrW + 1)'(FIFO_DEPTH);

  logic             ex_valid_q;
  logic [31:0]      ex_a_q, ex_b_q;
  logic [3:0]       ex_ctrl_q;
  logic [TAG_W-1:0] ex_tag_q;

  logic [PtrW-1:0]  wptr_q, rptr_q, fifo_count;
  logic [PtrW:0]    credit;
  logic [EntW-1:0]  mem_q [FIFO_DEPTH];
  logic [EntW-1:0]  head;
  logic [15:0]      op_count_q;

  logic             accept, push, pop;
  logic             legal, is_add, is_sub;
  logic [31:0]      push_data;
  logic [2:0]       push_flags;

  assign fifo_count = wptr_q - rptr_q;
  // Credit check counts the op in the issue register, so a push never overflows.
  assign credit     = {1'b0, fifo_count} + {{PtrW{1'b0}}, ex_valid_q};
  assign in_ready   = credit < DepthW;
  assign accept     = in_valid && in_ready;
  assign push       = ex_valid_q;
  assign res_valid  = (fifo_count != '0);
  assign pop        = res_valid && res_ready;

  assign alu_a    = ex_a_q;
  assign alu_b    = ex_b_q;
  assign alu_ctrl = ex_ctrl_q;
  assign op_count = op_count_q;

  // Decode legality and mask flags that carry no meaning for the executed op.
  always_comb begin
    legal      = 1'b0;
    is_add     = (ex_ctrl_q == 4'b0010);
    is_sub     = (ex_ctrl_q == 4'b0110);
    push_data  = '0;
    push_flags = '0;
    case (ex_ctrl_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    if (legal) begin
      push_data  = alu_out;
      push_flags = {alu_ovf & (is_add | is_sub), alu_carry & is_add, alu_zero};
    end
  end

  // Issue register, FIFO pointers and op counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_a_q     <= '0;
      ex_b_q     <= '0;
      ex_ctrl_q  <= '0;
      ex_tag_q   <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      op_count_q <= '0;
    end else begin
      ex_valid_q <= accept;
      // Operands hold their last value when idle so the ALU inputs do not toggle.
      if (accept) begin
        ex_a_q    <= in_a;
        ex_b_q    <= in_b;
        ex_ctrl_q <= in_ctrl;
        ex_tag_q  <= in_tag;
      end
      if (push) begin
        wptr_q     <= wptr_q + 1'b1;
        op_count_q <= op_count_q + 16'd1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
    end
  end

  // FIFO storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q[AddrW-1:0]] <= {~legal, push_flags, ex_tag_q, push_data};
    end
  end

  // Head entry, forced to zero while the FIFO is empty.
  always_comb begin
    head = '0;
    if (res_valid) begin
      head = mem_q[rptr_q[AddrW-1:0]];
    end
  end

  assign res_data    = head[31:0];
  assign res_tag     = head[32 +: TAG_W];
  assign res_flags   = head[32 + TAG_W +: 3];
  assign res_illegal = head[EntW-1];

`ifdef ALU_EXEC_STICKY_EN
  logic sticky_q;

  // Sticky overflow: a set on push takes priority over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= 1'b0;
    end else if (push && push_flags[2]) begin
      sticky_q <= 1'b1;
    end else if (sticky_clr) begin
      sticky_q <= 1'b0;
    end
  end

  assign sticky_ovf = sticky_q;
`else
  logic sticky_clr_unused;
  assign sticky_clr_unused = sticky_clr;
  assign sticky_ovf        = 1'b0;
`endif

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage wrapped around the combinational `ALU_32`. It accepts operations over a valid/ready handshake and drives the ALU's `A_in`, `B_in` and `ALU_ctrl` from a one-entry issue register. It captures `ALU_out` and the flags into a result FIFO and presents them to writeback over a second valid/ready handshake. It also masks flags that are not meaningful for the executed op and flags unsupported control codes.

## Interface
- `FIFO_DEPTH`, 4: result FIFO entries; power of 2, minimum 2.
- `TAG_W`, 4: width of the opaque tag carried with each op.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `in_valid` in 1: op offered.
- `in_ready` out 1: stage accepts op this cycle.
- `in_a` in 32: operand A.
- `in_b` in 32: operand B.
- `in_ctrl` in 4: ALU control code.
- `in_tag` in TAG_W: tag returned with the result.
- `alu_a` out 32: to `ALU_32.A_in`.
- `alu_b` out 32: to `ALU_32.B_in`.
- `alu_ctrl` out 4: to `ALU_32.ALU_ctrl`.
- `alu_out` in 32: from `ALU_32.ALU_out`.
- `alu_carry` in 1: from `ALU_32.carry_out`.
- `alu_zero` in 1: from `ALU_32.zero`.
- `alu_ovf` in 1: from `ALU_32.overflow`.
- `res_valid` out 1: result at FIFO head.
- `res_ready` in 1: consumer takes result.
- `res_data` out 32: result value.
- `res_tag` out TAG_W: tag of the result.
- `res_flags` out 3: {overflow, carry, zero}, masked.
- `res_illegal` out 1: ctrl code unsupported.
- `op_count` out 16: results pushed since reset; wraps.
- `sticky_ovf` out 1: accumulated overflow (see Configuration).
- `sticky_clr` in 1: clears `sticky_ovf`.

## Operation
- Legal codes are 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR and 1111 EQ. All other codes are illegal.
- Issue register: `ex_valid`, a, b, ctrl, tag. Load it on `in_valid && in_ready`; otherwise clear `ex_valid`. The issue register never stalls.
- `alu_a/b/ctrl` come straight from the issue register. When `ex_valid`=0 they hold the last value; do not toggle them.
- `in_ready` = (fifo_count + ex_valid) < FIFO_DEPTH. This is a credit check, so the captured op always has a FIFO slot.
- Capture: when `ex_valid`=1, push {alu_out, tag, flags, illegal} into the FIFO at the end of that cycle.
- Flag masking:
  - carry = `alu_carry` only for ADD; otherwise 0.
  - overflow = `alu_ovf` only for ADD and SUB; otherwise 0.
  - zero = `alu_zero` for all legal ops.
- Illegal op: push data 0, flags 000 and illegal=1. The ALU outputs are ignored.
- Pop: on `res_valid && res_ready`. A push and a pop in the same cycle are both performed, and the count is unchanged.
- FIFO read/write pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally. The extra bit distinguishes full from empty.
- `op_count` increments on every push, including illegal ones, and wraps from FFFF to 0000.
- Outputs are driven from the FIFO head only. When the FIFO is empty, `res_data`, `res_tag`, `res_flags` and `res_illegal` read 0.

## Timing
- Reset values, applied asynchronously on `rst_n`=0:
  - `ex_valid`=0, pointers=0, `res_valid`=0, `in_ready`=1, `op_count`=0, `sticky_ovf`=0.
  - All data outputs and `alu_a/b/ctrl` = 0.
- Latency: op accepted at edge N → ALU driven in cycle N+1 → pushed at edge N+1 → `res_valid`=1 in cycle N+2 when the FIFO was empty. Minimum latency is 2 cycles.
- Throughput is 1 op/cycle when `res_ready` is held at 1.
- `in_ready` is combinational on state only. It never depends on `in_valid` or `res_ready` in the same cycle.
- Full condition: with FIFO_DEPTH-1 entries plus `ex_valid`=1, `in_ready`=0.
- Full and popping: if `res_ready` pops while full, `in_ready` rises the next cycle, not the same cycle.
- Reset mid-operation: an in-flight issue-register op and all FIFO contents are discarded. No result is presented after `rst_n` deasserts.
- `res_valid` and the payload are stable while `res_ready`=0.

## Configuration
- Macro `ALU_EXEC_STICKY_EN`.
- Defined:
  - `sticky_ovf` sets on any push with overflow=1.
  - `sticky_clr`=1 clears it at the next edge.
  - If set and clear happen together, set wins.
- Undefined: `sticky_ovf` is tied to 0, `sticky_clr` is ignored, and no flop is inferred.
- Ports are identical in both builds.

## Test plan
- ADD: A=C182F088, B=D07915C2, ctrl=0010, `res_ready`=1 → 2 cycles later `res_data`=91FC064A, flags=010 (carry=1, ovf=0).
- SUB: A=B182F088, B=707915C3, ctrl=0110 → `res_data`=4109DAC5, flags=100. With `ALU_EXEC_STICKY_EN`, `sticky_ovf`=1 the next cycle.
- NOR: A=E491C062, B=5B7E7F9D, ctrl=1100 → `res_data`=00000000, flags=001. Then ctrl=0011 → `res_illegal`=1, data=0, flags=000.
- Backpressure: hold `res_ready`=0 and stream 6 ops (tags 0–5).
  - Exactly 4 are accepted and `in_ready` drops.
  - Releasing `res_ready` yields tags 0,1,2,3 in order, and `in_ready` rises one cycle after the first pop.
- Streaming 70000 ops → `op_count` wraps to 70000−65536 = 4464 (0x1170).
- Reset: assert `rst_n`=0 with 3 results queued and 1 in the issue register → `res_valid`=0 and `op_count`=0 immediately. After release, no stale result appears.
